// File: rtl/mc_control.sv
// Multi-cycle control sequencer for the MIPS core: walks each instruction
// through fetch/decode/execute/memory/writeback and drives datapath selects.
module mc_control #(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          ir_opcode,
    input  logic [5:0]          ir_funct,
    input  logic                mem_ready,
    output logic [5:0]          alu_opcode,
    output logic [5:0]          alu_funct,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic                pc_write,
    output logic                ir_write,
    output logic                ab_write,
    output logic                aluout_write,
    output logic                mdr_write,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                mem_req,
    output logic                mem_we,
    output logic                iord,
    output logic                halted,
    output logic [2:0]          state,
    output logic [RETIRE_W-1:0] retired
);

    localparam logic [2:0] S_FETCH    = 3'd0;
    localparam logic [2:0] S_DECODE   = 3'd1;
    localparam logic [2:0] S_EXEC     = 3'd2;
    localparam logic [2:0] S_MEM_ADDR = 3'd3;
    localparam logic [2:0] S_MEM_RD   = 3'd4;
    localparam logic [2:0] S_MEM_WR   = 3'd5;
    localparam logic [2:0] S_WB       = 3'd6;
    localparam logic [2:0] S_TRAP     = 3'd7;

    localparam logic [5:0] OPCODE_R     = 6'h00;
    localparam logic [5:0] OPCODE_ADDI  = 6'h08;
    localparam logic [5:0] OPCODE_ADDIU = 6'h09;
    localparam logic [5:0] OPCODE_LW    = 6'h23;
    localparam logic [5:0] OPCODE_SW    = 6'h2B;

    localparam logic [5:0] FUNCT_NOOP = 6'h00;
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU = 6'h2B;

    logic [2:0]          r_state;
    logic [2:0]          w_next;
    logic                r_halted;
    logic [RETIRE_W-1:0] r_retired;
    logic                w_retire;
    logic                w_rtype;
    logic                w_alu_r;
    logic                w_itype;
    logic                w_mem;
    logic                w_noop;

    assign w_rtype = (ir_opcode == OPCODE_R);
    assign w_noop  = w_rtype && (ir_funct == FUNCT_NOOP);
    assign w_itype = (ir_opcode == OPCODE_ADDI) || (ir_opcode == OPCODE_ADDIU);
    assign w_mem   = (ir_opcode == OPCODE_LW) || (ir_opcode == OPCODE_SW);

    always_comb begin
        w_alu_r = 1'b0;
        if (w_rtype) begin
            case (ir_funct)
                FUNCT_ADD, FUNCT_ADDU, FUNCT_SUB,
                FUNCT_SUBU, FUNCT_SLT, FUNCT_SLTU: w_alu_r = 1'b1;
                default:                           w_alu_r = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_halted  <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_next == S_TRAP)
                r_halted <= 1'b1;
            if (w_retire)
                r_retired <= r_retired + {{(RETIRE_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        case (r_state)
            S_FETCH:
                if (mem_ready) w_next = S_DECODE;
            S_DECODE:
                if (w_alu_r || w_itype) begin
                    w_next = S_EXEC;
                end else if (w_noop) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end else if (w_mem) begin
                    w_next = S_MEM_ADDR;
                end else begin
                    w_next = S_TRAP;
                end
            S_EXEC:
                w_next = S_WB;
            S_MEM_ADDR:
                w_next = (ir_opcode == OPCODE_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:
                if (mem_ready) w_next = S_WB;
            S_MEM_WR:
                if (mem_ready) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end
            S_WB: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_TRAP:
                w_next = S_TRAP;
            default:
                w_next = S_FETCH;
        endcase
    end

    // Strobes are held at defaults whenever reset is asserted.
    always_comb begin
        alu_opcode   = OPCODE_R;
        alu_funct    = FUNCT_NOOP;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'd0;
        pc_write     = 1'b0;
        ir_write     = 1'b0;
        ab_write     = 1'b0;
        aluout_write = 1'b0;
        mdr_write    = 1'b0;
        reg_write    = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        iord         = 1'b0;
        if (rst_n) begin
            case (r_state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        alu_opcode = OPCODE_ADDIU;
                        alu_src_b  = 2'd1;
                    end
                end
                S_DECODE:
                    ab_write = 1'b1;
                S_EXEC: begin
                    alu_opcode   = ir_opcode;
                    alu_funct    = ir_funct;
                    alu_src_a    = 1'b1;
                    alu_src_b    = w_rtype ? 2'd0 : 2'd2;
                    aluout_write = 1'b1;
                end
                S_MEM_ADDR: begin
                    alu_opcode   = ir_opcode;
                    alu_src_a    = 1'b1;
                    alu_src_b    = 2'd2;
                    aluout_write = 1'b1;
                end
                S_MEM_RD: begin
                    mem_req   = 1'b1;
                    iord      = 1'b1;
                    mdr_write = mem_ready;
                end
                S_MEM_WR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    iord    = 1'b1;
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = w_rtype;
                    mem_to_reg = (ir_opcode == OPCODE_LW);
                end
                default: ;
            endcase
        end
    end

    assign state   = r_state;
    assign halted  = r_halted;
    assign retired = r_retired;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: directed scenarios plus random
// instruction streams, checked against an instruction-level timing model.
module tb_mc_control;

    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [5:0]    ir_opcode = 6'h00;
    logic [5:0]    ir_funct = 6'h00;
    logic          mem_ready = 1'b0;
    logic [5:0]    alu_opcode;
    logic [5:0]    alu_funct;
    logic          alu_src_a;
    logic [1:0]    alu_src_b;
    logic          pc_write;
    logic          ir_write;
    logic          ab_write;
    logic          aluout_write;
    logic          mdr_write;
    logic          reg_write;
    logic          reg_dst;
    logic          mem_to_reg;
    logic          mem_req;
    logic          mem_we;
    logic          iord;
    logic          halted;
    logic [2:0]    state;
    logic [RW-1:0] retired;

    mc_control #(.RETIRE_W(RW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ir_opcode(ir_opcode), .ir_funct(ir_funct),
        .mem_ready(mem_ready),
        .alu_opcode(alu_opcode), .alu_funct(alu_funct),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_write(pc_write), .ir_write(ir_write),
        .ab_write(ab_write), .aluout_write(aluout_write),
        .mdr_write(mdr_write), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .halted(halted), .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    localparam int C_NOOP = 0;
    localparam int C_R    = 1;
    localparam int C_I    = 2;
    localparam int C_LW   = 3;
    localparam int C_SW   = 4;
    localparam int C_ILL  = 5;

    int tests = 0;
    int fails = 0;
    int model_ret = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int cls_of(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) begin
            if (fn == 6'h00) return C_NOOP;
            if (fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h2A, 6'h2B}) return C_R;
            return C_ILL;
        end
        if (op == 6'h08 || op == 6'h09) return C_I;
        if (op == 6'h23) return C_LW;
        if (op == 6'h2B) return C_SW;
        return C_ILL;
    endfunction

    function automatic logic [31:0] strobes();
        return 32'({pc_write, ir_write, ab_write, aluout_write, mdr_write,
                    reg_write, mem_req, mem_we, iord, reg_dst, mem_to_reg});
    endfunction

    task automatic chk_ret(input string tag);
        chk(tag, 32'(retired), 32'(model_ret % 16));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem_ready = 1'b1;
        ir_opcode = 6'h00;
        ir_funct = 6'h20;
        @(negedge clk);
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_strobes", strobes(), 32'd0);
        chk("rst_aluop", 32'(alu_opcode), 32'd0);
        chk("rst_alufn", 32'(alu_funct), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b0;
        model_ret = 0;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int wf, input int wd, input bit abort);
        int c;
        c = cls_of(op, fn);
        ir_opcode = op;
        ir_funct = fn;
        for (int w = 0; w <= wf; w++) begin
            mem_ready = (w == wf);
            #1;
            chk("fetch_state", 32'(state), 32'd0);
            chk("fetch_req", 32'(mem_req), 32'd1);
            chk("fetch_iord", 32'(iord), 32'd0);
            chk("fetch_irw", 32'(ir_write), 32'(mem_ready));
            chk("fetch_pcw", 32'(pc_write), 32'(mem_ready));
            chk("fetch_halted", 32'(halted), 32'd0);
            chk_ret("fetch_retired");
            if (mem_ready) begin
                chk("pc4_aluop", 32'(alu_opcode), 32'h09);
                chk("pc4_srcb", 32'(alu_src_b), 32'd1);
            end
            @(negedge clk);
        end
        mem_ready = 1'($urandom_range(0, 1));
        #1;
        chk("dec_state", 32'(state), 32'd1);
        chk("dec_abw", 32'(ab_write), 32'd1);
        chk("dec_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        case (c)
            C_NOOP: model_ret++;
            C_R, C_I: begin
                mem_ready = 1'($urandom_range(0, 1));
                #1;
                chk("ex_state", 32'(state), 32'd2);
                chk("ex_aluop", 32'(alu_opcode), 32'(op));
                chk("ex_alufn", 32'(alu_funct), 32'(fn));
                chk("ex_srca", 32'(alu_src_a), 32'd1);
                chk("ex_srcb", 32'(alu_src_b), (c == C_R) ? 32'd0 : 32'd2);
                chk("ex_aluoutw", 32'(aluout_write), 32'd1);
                @(negedge clk);
                mem_ready = 1'($urandom_range(0, 1));
                #1;
                chk("wb_state", 32'(state), 32'd6);
                chk("wb_regw", 32'(reg_write), 32'd1);
                chk("wb_dst", 32'(reg_dst), (c == C_R) ? 32'd1 : 32'd0);
                chk("wb_m2r", 32'(mem_to_reg), 32'd0);
                @(negedge clk);
                model_ret++;
            end
            C_LW, C_SW: begin
                mem_ready = 1'($urandom_range(0, 1));
                #1;
                chk("ma_state", 32'(state), 32'd3);
                chk("ma_aluop", 32'(alu_opcode), 32'(op));
                chk("ma_srca", 32'(alu_src_a), 32'd1);
                chk("ma_srcb", 32'(alu_src_b), 32'd2);
                chk("ma_aluoutw", 32'(aluout_write), 32'd1);
                chk("ma_req", 32'(mem_req), 32'd0);
                @(negedge clk);
                for (int w = 0; w <= wd; w++) begin
                    if (abort && w == 1) begin
                        rst_n = 1'b0;
                        mem_ready = 1'b1;
                        #1;
                        chk("abort_req_low", 32'(mem_req), 32'd0);
                        chk("abort_strobes", strobes(), 32'd0);
                        @(negedge clk);
                        #1;
                        chk("abort_state", 32'(state), 32'd0);
                        chk("abort_retired", 32'(retired), 32'd0);
                        chk("abort_req", 32'(mem_req), 32'd0);
                        rst_n = 1'b1;
                        mem_ready = 1'b0;
                        model_ret = 0;
                        @(negedge clk);
                        return;
                    end
                    mem_ready = (w == wd);
                    #1;
                    chk("mem_req", 32'(mem_req), 32'd1);
                    chk("mem_iord", 32'(iord), 32'd1);
                    if (c == C_LW) begin
                        chk("rd_state", 32'(state), 32'd4);
                        chk("rd_mdrw", 32'(mdr_write), 32'(mem_ready));
                        chk("rd_we", 32'(mem_we), 32'd0);
                    end else begin
                        chk("wr_state", 32'(state), 32'd5);
                        chk("wr_we", 32'(mem_we), 32'd1);
                    end
                    @(negedge clk);
                end
                if (c == C_LW) begin
                    mem_ready = 1'($urandom_range(0, 1));
                    #1;
                    chk("lwb_state", 32'(state), 32'd6);
                    chk("lwb_regw", 32'(reg_write), 32'd1);
                    chk("lwb_m2r", 32'(mem_to_reg), 32'd1);
                    chk("lwb_dst", 32'(reg_dst), 32'd0);
                    @(negedge clk);
                end
                model_ret++;
            end
            default: begin
                for (int k = 0; k < 6; k++) begin
                    mem_ready = 1'($urandom_range(0, 1));
                    ir_opcode = 6'($urandom);
                    ir_funct = 6'($urandom);
                    #1;
                    chk("trap_state", 32'(state), 32'd7);
                    chk("trap_halted", 32'(halted), 32'd1);
                    chk("trap_strobes", strobes(), 32'd0);
                    chk("trap_aluop", 32'(alu_opcode), 32'd0);
                    chk_ret("trap_retired");
                    @(negedge clk);
                end
            end
        endcase
    endtask

    task automatic run_random();
        logic [5:0] op;
        logic [5:0] fn;
        int sel;
        sel = $urandom_range(0, 10);
        fn = 6'($urandom);
        case (sel)
            0: begin op = 6'h00; fn = 6'h20; end
            1: begin op = 6'h00; fn = 6'h21; end
            2: begin op = 6'h00; fn = 6'h22; end
            3: begin op = 6'h00; fn = 6'h23; end
            4: begin op = 6'h00; fn = 6'h2A; end
            5: begin op = 6'h00; fn = 6'h2B; end
            6: begin op = 6'h00; fn = 6'h00; end
            7: op = 6'h08;
            8: op = 6'h09;
            9: op = 6'h23;
            default: op = 6'h2B;
        endcase
        run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
    endtask

    initial begin
        do_reset();
        run_instr(6'h00, 6'h20, 0, 0, 1'b0);
        chk("add_retired", 32'(retired), 32'd1);
        run_instr(6'h23, 6'h00, 0, 2, 1'b0);
        run_instr(6'h2B, 6'h11, 0, 0, 1'b0);
        run_instr(6'h09, 6'h05, 0, 0, 1'b0);
        chk("sw_addiu_retired", 32'(retired), 32'd4);
        for (int i = 0; i < 25; i++) run_random();

        do_reset();
        for (int i = 0; i < 3; i++) run_random();
        run_instr(6'h3F, 6'h00, 0, 0, 1'b0);
        chk("ill_retired", 32'(retired), 32'd3);

        do_reset();
        run_instr(6'h00, 6'h00, 0, 0, 1'b0);
        run_instr(6'h23, 6'h00, 0, 2, 1'b1);
        run_instr(6'h00, 6'h22, 1, 0, 1'b0);
        chk("resume_retired", 32'(retired), 32'd1);

        do_reset();
        for (int i = 1; i <= 17; i++) begin
            run_instr(6'h00, 6'h00, 0, 0, 1'b0);
            if (i == 16) chk("wrap16", 32'(retired), 32'd0);
            if (i == 17) chk("wrap17", 32'(retired), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
